// File: rtl/gate_lib_pkg.sv
// Shared definitions for the logic-gate library: op encoding, base-op classes
// and the elaboration-time helpers used to size the reduction tree.
package gate_lib_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        BASE_AND = 2'd0,
        BASE_OR  = 2'd1,
        BASE_XOR = 2'd2
    } base_e;

    // Reserved ops map to AND; their result is forced to 0 at the last stage anyway.
    function automatic base_e base_op(input logic [OP_W-1:0] op);
        case (op)
            3'd1, 3'd4: return BASE_OR;
            3'd2, 3'd5: return BASE_XOR;
            default:    return BASE_AND;
        endcase
    endfunction

    function automatic logic identity(input base_e base);
        return base == BASE_AND;
    endfunction

    function automatic logic is_inverted(input logic [OP_W-1:0] op);
        return (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
    endfunction

    function automatic logic is_reserved(input logic [OP_W-1:0] op);
        return op[2] && op[1];
    endfunction

    function automatic int unsigned clog4(input int unsigned n);
        int unsigned s;
        int unsigned cap;
        s   = 0;
        cap = 1;
        while (cap < n) begin
            cap = cap * 4;
            s   = s + 1;
        end
        return (s == 0) ? 1 : s;
    endfunction

    // Bit width entering tree level k.
    function automatic int unsigned stage_w(input int unsigned n, input int unsigned k);
        int unsigned w;
        w = n;
        for (int unsigned i = 0; i < k; i++) begin
            w = (w + 3) / 4;
        end
        return w;
    endfunction

endpackage

// File: rtl/reduce4_stage.sv
// One level of the radix-4 reduction tree: groups of four bits reduced with the
// base op and registered together with op, valid and error under a shared enable.
module reduce4_stage
    import gate_lib_pkg::*;
#(
    parameter int unsigned W_IN = 4,
    parameter bit          LAST = 1'b0,
    localparam int unsigned W_OUT = (W_IN + 3) / 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              v_i,
    input  logic [W_IN-1:0]   d_i,
    input  logic [OP_W-1:0]   op_i,
    input  logic              err_i,
    output logic              v_o,
    output logic [W_OUT-1:0]  d_o,
    output logic [OP_W-1:0]   op_o,
    output logic              err_o
);

    base_e                base_c;
    logic [4*W_OUT-1:0]   pad_c;
    logic [W_OUT-1:0]     red_c;
    logic [W_OUT-1:0]     nxt_c;

    // Unused leaves carry the base op's identity so they never change the result.
    always_comb begin
        base_c = base_op(op_i);
        pad_c  = {(4*W_OUT){identity(base_c)}};
        pad_c[W_IN-1:0] = d_i;
        red_c  = '0;
        for (int j = 0; j < int'(W_OUT); j++) begin
            case (base_c)
                BASE_OR:  red_c[j] = |pad_c[4*j +: 4];
                BASE_XOR: red_c[j] = ^pad_c[4*j +: 4];
                default:  red_c[j] = &pad_c[4*j +: 4];
            endcase
        end
    end

    always_comb begin
        nxt_c = red_c;
        if (LAST && err_i) begin
            nxt_c = '0;
        end else if (LAST && is_inverted(op_i)) begin
            nxt_c = ~red_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_o   <= 1'b0;
            d_o   <= '0;
            op_o  <= '0;
            err_o <= 1'b0;
        end else if (en) begin
            v_o   <= v_i;
            d_o   <= nxt_c;
            op_o  <= op_i;
            err_o <= err_i;
        end
    end

endmodule

// File: rtl/reduce_gate_pipe.sv
// Pipelined N-input reduction gate (AND/OR/XOR and inverses) built as a
// radix-4 tree, one register per level, with valid/ready and a hit counter.
module reduce_gate_pipe
    import gate_lib_pkg::*;
#(
    parameter int unsigned N_IN  = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_data,
    input  logic [OP_W-1:0]   in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_data,
    output logic              out_err,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  hit_count
);

    localparam int unsigned STAGES = clog4(N_IN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              stall_c;
    logic              stage_v   [STAGES+1];
    logic [OP_W-1:0]   stage_op  [STAGES+1];
    logic              stage_err [STAGES+1];
    logic [OP_W-1:0]   unused_op;

    // A held output freezes the whole tree; in_ready is a direct path from out_ready.
    assign stall_c  = out_valid && !out_ready;
    assign in_ready = !stall_c;

    assign stage_v[0]   = in_valid;
    assign stage_op[0]  = in_op;
    assign stage_err[0] = is_reserved(in_op);

    for (genvar k = 0; k < STAGES; k++) begin : g_lvl
        localparam int unsigned WI = stage_w(N_IN, k);
        localparam int unsigned WO = (WI + 3) / 4;

        logic [WI-1:0] d_in;
        logic [WO-1:0] d;

        if (k == 0) begin : g_first
            assign d_in = in_data;
        end else begin : g_next
            assign d_in = g_lvl[k-1].d;
        end

        reduce4_stage #(
            .W_IN (WI),
            .LAST (k == STAGES - 1)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (!stall_c),
            .v_i   (stage_v[k]),
            .d_i   (d_in),
            .op_i  (stage_op[k]),
            .err_i (stage_err[k]),
            .v_o   (stage_v[k+1]),
            .d_o   (d),
            .op_o  (stage_op[k+1]),
            .err_o (stage_err[k+1])
        );
    end

    assign out_valid = stage_v[STAGES];
    assign out_err   = stage_err[STAGES];
    assign out_data  = g_lvl[STAGES-1].d[0];
    assign unused_op = stage_op[STAGES];

    // Saturating count of accepted non-error ones; clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count <= '0;
        end else if (cnt_clr) begin
            hit_count <= '0;
        end else if (out_valid && out_ready && out_data && !out_err && (hit_count != CNT_MAX)) begin
            hit_count <= hit_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/reduce_gate_pipe.md
Name: reduce_gate_pipe

Overview:
- Parametrised, pipelined N-input reduction gate; generalises the fixed 4-input AND primitive in the logic-gate library.
- Selectable op per transaction: AND / OR / XOR / NAND / NOR / XNOR.
- Built as a radix-4 reduction tree with one register per tree level and valid/ready flow control.
- Used wherever wide match/parity/all-ones detection must meet timing in the library's datapath blocks.

Parameters:
- N_IN, 16, number of input bits reduced (2..256).
- CNT_W, 16, width of the saturating hit counter.
- STAGES, derived localparam = ceil(log4(N_IN)), min 1; pipeline depth in cycles.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept input this cycle.
- in_data  in  N_IN  bits to reduce.
- in_op  in  3  op select: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6–7 reserved.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  1  reduction result.
- out_err  out  1  result came from a reserved op.
- cnt_clr  in  1  synchronous clear of hit_count.
- hit_count  out  CNT_W  number of accepted results with out_data=1, saturating.

Behaviour:
- Reset (rst_n=0, async): every pipeline valid bit, out_valid, out_data, out_err and hit_count go to 0. Stage data registers are also cleared.
- Accept: input fires when in_valid && in_ready. Output fires when out_valid && out_ready.
- Stall: global stall = out_valid && !out_ready.
  - in_ready = !stall (combinational from out_ready; documented path).
  - During stall, no pipeline register changes and out_data/out_err/out_valid hold stable.
- Latency: a fired input appears at the output exactly STAGES cycles later if no stall occurs. Throughput is 1 result/cycle.
- Bubbles: stage valid bits propagate with the data. A bubble must not produce out_valid.
- Op handling:
  - Each stage carries its data plus the 3-bit op.
  - Stage k reduces groups of 4 bits using the base op: AND for 0/3, OR for 1/4, XOR for 2/5.
  - The final stage applies inversion for ops 3/4/5.
- Padding: when N_IN is not a power of 4, unused tree leaves carry the base op's identity: 1 for AND, 0 for OR/XOR. For example, N_IN=5 AND of all ones gives 1.
- Reserved op (6/7): out_data=0 and out_err=1 for that transaction only. The transaction still consumes a pipeline slot and is not counted.
- hit_count:
  - Increments by 1 on each output fire with out_data=1 and out_err=0.
  - Saturates at 2^CNT_W−1 with no wrap.
- cnt_clr:
  - Sets hit_count to 0 next edge.
  - If asserted in the same cycle as a counting fire, clear wins and the result is 0.
  - cnt_clr does not affect the pipeline.
- Reset mid-operation: all in-flight transactions are discarded and no out_valid is asserted after release until a new input fires.
- N_IN ≤ 4: STAGES=1, i.e. a single registered level. The inversion and error logic is the same.

Decomposition:
- Shared package gate_lib_pkg:
  - op enum/localparams: OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR.
  - function base_op(op) → 2-bit base class.
  - function identity(base).
  - function clog4(n).
- Sub-module reduce4_stage:
  - Parametrised lane count.
  - Registers ceil(W/4) reduced bits, op and valid under a shared enable (!stall).
  - Top generates STAGES instances plus the output/counter logic.

Test Plan:
- Reset release, N_IN=16, op=AND, in_data=16'hFFFF for 1 cycle, out_ready=1 → out_valid=1 at cycle +2, out_data=1, hit_count=1. Then in_data=16'hFFFE → out_data=0, hit_count stays 1.
- Back-to-back stream, all ops on in_data=16'h0001 (AND, OR, XOR, NAND, NOR, XNOR) → outputs 0,1,1,1,0,0 on consecutive cycles. Check no bubbles, hit_count=3.
- Backpressure: 3 inputs in flight, out_ready=0 for 5 cycles → in_ready=0, out_data held. Release → all 3 results in order, none lost or duplicated.
- Reserved op=6 with in_data=16'hFFFF → out_data=0, out_err=1 for one result. Next valid AND result has out_err=0. hit_count unchanged.
- N_IN=5 instance: AND of 5'b11111 → 1; OR of 5'b00000 → 0. Proves padding identity.
- Saturation/clear with CNT_W=2: 4 hit results → hit_count=3 (saturated). cnt_clr coincident with a hit fire → hit_count=0. Async rst_n pulse mid-stream → out_valid=0 immediately, no stale result after release.
